// File: rtl/rv32i_alu_insn_encoder_pkg.sv
// Shared RV32I opcode/funct constants and the ALU operation codes driven into the encoder.
// The encoded buffer word packs the instruction with its illegal-request flag.
package rv32i_alu_insn_encoder_pkg;

  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd9;

  localparam logic [6:0] RV32_OP     = 7'b0110011;
  localparam logic [6:0] RV32_OP_IMM = 7'b0010011;

  localparam logic [2:0] RV32_FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] RV32_FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] RV32_FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] RV32_FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] RV32_FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] RV32_FUNCT3_SRA_SRL = 3'b101;
  localparam logic [2:0] RV32_FUNCT3_OR      = 3'b110;
  localparam logic [2:0] RV32_FUNCT3_AND     = 3'b111;

  localparam logic [6:0]  RV32_FUNCT7_ZERO = 7'h00;
  localparam logic [6:0]  RV32_FUNCT7_ALT  = 7'h20;
  localparam logic [31:0] RV32_NOP         = 32'h00000013;

  typedef struct packed {
    logic [31:0] insn;
    logic        err;
  } enc_word_t;

endpackage

// File: rtl/rv32_skid_buf2.sv
// Two-entry valid/ready FIFO; output comes straight from the head register and
// in_ready is registered from next-state occupancy so it has no path from in_valid/out_ready.
module rv32_skid_buf2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head, tail, head_n, tail_n;
  logic             head_v, tail_v, head_v_n, tail_v_n;
  logic             ready_q, ready_n;
  logic             push, pop;

  assign push      = in_valid & ready_q;
  assign pop       = head_v & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = head_v;
  assign out_data  = head;

  always_comb begin
    head_n   = head;
    tail_n   = tail;
    head_v_n = head_v;
    tail_v_n = tail_v;
    case ({push, pop})
      2'b10: begin
        if (!head_v) begin
          head_n   = in_data;
          head_v_n = 1'b1;
        end else begin
          tail_n   = in_data;
          tail_v_n = 1'b1;
        end
      end
      2'b01: begin
        head_n   = tail;
        head_v_n = tail_v;
        tail_v_n = 1'b0;
      end
      2'b11: begin
        // Simultaneous push/pop: occupancy unchanged, the queue just shifts.
        if (tail_v) begin
          head_n = tail;
          tail_n = in_data;
        end else begin
          head_n = in_data;
        end
      end
      default: ;
    endcase
    ready_n = ~(head_v_n & tail_v_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      head_v  <= 1'b0;
      tail_v  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      head_v  <= head_v_n;
      tail_v  <= tail_v_n;
      ready_q <= ready_n;
    end
  end

endmodule

// File: rtl/rv32i_alu_insn_encoder.sv
// Encodes an ALU op plus operands into an RV32I OP / OP-IMM word, buffered through a
// 2-entry skid buffer; illegal requests emit the canonical NOP with out_err set.
module rv32i_alu_insn_encoder
  import rv32i_alu_insn_encoder_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALU_OP_WIDTH-1:0] in_alu_op,
  input  logic                    in_use_imm,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [11:0]             in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_insn,
  output logic                    out_err,
  output logic [CNT_WIDTH-1:0]    insn_cnt
);

  enc_word_t enc, head;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal, is_shift;

  always_comb begin
    funct3   = RV32_FUNCT3_ADD_SUB;
    funct7   = RV32_FUNCT7_ZERO;
    legal    = 1'b1;
    is_shift = 1'b0;
    case (in_alu_op)
      ALU_OP_ADD:  funct3 = RV32_FUNCT3_ADD_SUB;
      ALU_OP_SUB:  begin funct3 = RV32_FUNCT3_ADD_SUB; funct7 = RV32_FUNCT7_ALT; end
      ALU_OP_SLL:  begin funct3 = RV32_FUNCT3_SLL; is_shift = 1'b1; end
      ALU_OP_SLT:  funct3 = RV32_FUNCT3_SLT;
      ALU_OP_SLTU: funct3 = RV32_FUNCT3_SLTU;
      ALU_OP_XOR:  funct3 = RV32_FUNCT3_XOR;
      ALU_OP_SRL:  begin funct3 = RV32_FUNCT3_SRA_SRL; is_shift = 1'b1; end
      ALU_OP_SRA:  begin funct3 = RV32_FUNCT3_SRA_SRL; funct7 = RV32_FUNCT7_ALT; is_shift = 1'b1; end
      ALU_OP_OR:   funct3 = RV32_FUNCT3_OR;
      ALU_OP_AND:  funct3 = RV32_FUNCT3_AND;
      default:     legal = 1'b0;
    endcase

    if (in_use_imm) begin
      if (in_alu_op == ALU_OP_SUB) legal = 1'b0;
      if (is_shift && (in_imm[11:5] != 7'd0)) legal = 1'b0;
      if (is_shift)
        enc.insn = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, RV32_OP_IMM};
      else
        enc.insn = {in_imm, in_rs1, funct3, in_rd, RV32_OP_IMM};
    end else begin
      enc.insn = {funct7, in_rs2, in_rs1, funct3, in_rd, RV32_OP};
    end
    enc.err = ~legal;
    if (!legal) enc.insn = RV32_NOP;
  end

  rv32_skid_buf2 #(.WIDTH(33)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (enc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_insn = head.insn;
  assign out_err  = head.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      insn_cnt <= '0;
    else if (out_valid && out_ready)
      insn_cnt <= insn_cnt + 1'b1;
  end

endmodule

// File: tb/tb_rv32i_alu_insn_encoder.sv
// Directed bench for the RV32I ALU instruction encoder: encodings, illegal requests,
// backpressure ordering, mid-transfer reset and a 4-bit counter wrap.
module tb_rv32i_alu_insn_encoder;
  import rv32i_alu_insn_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic        in_use_imm;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_err;
  logic [3:0]  insn_cnt;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_cnt;

  typedef struct packed {
    logic [3:0]  op;
    logic        use_imm;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] insn;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  rv32i_alu_insn_encoder #(.CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_op  (in_alu_op),
    .in_use_imm (in_use_imm),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_insn   (out_insn),
    .out_err    (out_err),
    .insn_cnt   (insn_cnt)
  );

  task automatic drive(input vec_t v);
    in_alu_op  = v.op;
    in_use_imm = v.use_imm;
    in_rd      = v.rd;
    in_rs1     = v.rs1;
    in_rs2     = v.rs2;
    in_imm     = v.imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_insn !== 32'h0) begin failures++; $display("FAIL reset_out_insn got=%h exp=00000000", out_insn); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    checks++; if (insn_cnt !== 4'd0) begin failures++; $display("FAIL reset_insn_cnt got=%0d exp=0", insn_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_encode();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL enc%0d_in_ready got=%b exp=1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL enc%0d_out_valid got=%b exp=1", i, out_valid); end
      checks++; if (out_insn !== vecs[i].insn) begin failures++; $display("FAIL enc%0d_insn got=%h exp=%h", i, out_insn, vecs[i].insn); end
      checks++; if (out_err !== vecs[i].err) begin failures++; $display("FAIL enc%0d_err got=%b exp=%b", i, out_err, vecs[i].err); end
      @(negedge clk);
      exp_cnt = exp_cnt + 4'd1;
      checks++; if (insn_cnt !== exp_cnt) begin failures++; $display("FAIL enc%0d_cnt got=%0d exp=%0d", i, insn_cnt, exp_cnt); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL enc%0d_drained got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; drive(vecs[0]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got=%b exp=1", in_ready); end
    checks++; if (out_insn !== 32'h003100B3) begin failures++; $display("FAIL bp_head1 got=%h exp=003100B3", out_insn); end
    drive(vecs[1]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
    drive(vecs[7]);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full2 got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_insn !== 32'h003100B3 || out_err !== 1'b0) begin
      failures++; $display("FAIL bp_head_stable got=%b/%h/%b exp=1/003100B3/0", out_valid, out_insn, out_err); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_insn !== 32'h407302B3) begin failures++; $display("FAIL bp_word2 got=%h exp=407302B3", out_insn); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_insn !== 32'h01FFFFB3) begin
      failures++; $display("FAIL bp_word3 got=%b/%h exp=1/01FFFFB3", out_valid, out_insn); end
    @(negedge clk);
    exp_cnt = exp_cnt + 4'd3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    checks++; if (insn_cnt !== exp_cnt) begin failures++; $display("FAIL bp_cnt got=%0d exp=%0d", insn_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; drive(vecs[0]);
    @(negedge clk);
    drive(vecs[1]);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rst_full got=%b/%b exp=0/1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
    checks++; if (insn_cnt !== 4'd0) begin failures++; $display("FAIL rst_async_cnt got=%0d exp=0", insn_cnt); end
    @(negedge clk);
    rst_n = 1'b1; exp_cnt = 4'd0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; drive(vecs[2]);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_insn !== 32'h4035D513 || out_err !== 1'b0) begin
      failures++; $display("FAIL rst_first got=%b/%h/%b exp=1/4035D513/0", out_valid, out_insn, out_err); end
    @(negedge clk);
    checks++; if (insn_cnt !== 4'd1) begin failures++; $display("FAIL rst_first_cnt got=%0d exp=1", insn_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_word;
    do_reset();
    out_ready = 1'b1;
    in_alu_op = ALU_OP_ADD; in_use_imm = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 12'd0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_word = (32'(i - 1) << 7) | 32'h33;
        checks++; if (out_valid !== 1'b1 || out_insn !== exp_word) begin
          failures++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i - 1, out_valid, out_insn, exp_word); end
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
      in_valid = 1'b1;
      in_rd = 5'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_insn !== 32'h00000833) begin
      failures++; $display("FAIL b2b_word16 got=%b/%h exp=1/00000833", out_valid, out_insn); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    checks++; if (insn_cnt !== 4'd1) begin failures++; $display("FAIL b2b_wrap_cnt got=%0d exp=1", insn_cnt); end
  endtask

  initial begin
    //            op           imm   rd     rs1    rs2    imm       insn           err
    vecs[0]  = '{ALU_OP_ADD,  1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h003100B3, 1'b0};
    vecs[1]  = '{ALU_OP_SUB,  1'b0, 5'd5,  5'd6,  5'd7,  12'h000, 32'h407302B3, 1'b0};
    vecs[2]  = '{ALU_OP_SRA,  1'b1, 5'd10, 5'd11, 5'd0,  12'h003, 32'h4035D513, 1'b0};
    vecs[3]  = '{ALU_OP_ADD,  1'b1, 5'd1,  5'd0,  5'd0,  12'hFFF, 32'hFFF00093, 1'b0};
    vecs[4]  = '{ALU_OP_SUB,  1'b1, 5'd1,  5'd2,  5'd3,  12'h001, 32'h00000013, 1'b1};
    vecs[5]  = '{ALU_OP_SLL,  1'b1, 5'd1,  5'd2,  5'd0,  12'h020, 32'h00000013, 1'b1};
    vecs[6]  = '{4'hC,        1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h00000013, 1'b1};
    vecs[7]  = '{ALU_OP_AND,  1'b0, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFFFB3, 1'b0};
    vecs[8]  = '{ALU_OP_XOR,  1'b1, 5'd2,  5'd3,  5'd0,  12'h800, 32'h8001C113, 1'b0};
    vecs[9]  = '{ALU_OP_SLTU, 1'b0, 5'd4,  5'd5,  5'd6,  12'h000, 32'h0062B233, 1'b0};
    vecs[10] = '{ALU_OP_SRL,  1'b1, 5'd1,  5'd1,  5'd0,  12'h01F, 32'h01F0D093, 1'b0};
    vecs[11] = '{ALU_OP_SLL,  1'b0, 5'd3,  5'd4,  5'd5,  12'h000, 32'h005211B3, 1'b0};
    vecs[12] = '{ALU_OP_OR,   1'b1, 5'd7,  5'd8,  5'd31, 12'h123, 32'h12346393, 1'b0};
    vecs[13] = '{ALU_OP_SLT,  1'b1, 5'd9,  5'd10, 5'd0,  12'h7FF, 32'h7FF52493, 1'b0};

    test_reset();
    test_encode();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
